// File: rtl/fb_bank_ctrl.sv
// fb_bank_ctrl: double-buffer bank controller for two frame-buffer RAM banks.
// The camera writes bank wr_bank while the display reads bank rd_bank. Banks
// swap on a display VSync falling edge once a full camera frame is pending.
// Optional macro FB_FRAME_STATS_EN builds the drop/short frame counters;
// without it drop_cnt and short_cnt are tied to zero.
module fb_bank_ctrl #(
    parameter int unsigned ADDR_W       = 19,
    parameter int unsigned FRAME_PIXELS = 307200
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cam_vsync,
    input  logic              cam_valid,
    input  logic [23:0]       cam_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              wr_bank,
    input  logic              disp_vsync,
    input  logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_bank,
    output logic              frame_sync,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       short_cnt
);

    localparam logic [ADDR_W-1:0] LastPix = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

    typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic              pending_q, pending_d;
    logic              disp_vsync_q;
    logic              wr_en_d;
    logic              wr_bank_q, rd_bank_q;
    logic [ADDR_W-1:0] wr_addr_q, rd_cnt_q;
    logic [23:0]       wr_data_q;
    logic              swap;
    logic              last_pix;

    // pending is sampled registered, so a final pixel and a display fall in the
    // same cycle do not swap until the next display frame
    assign swap     = disp_vsync_q & ~disp_vsync & pending_q;
    assign last_pix = (state_q == StCapture) & cam_valid & (pix_cnt_q == LastPix);

    // Writer FSM state, pixel count, pending flag and display VSync history
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            pix_cnt_q    <= '0;
            pending_q    <= 1'b0;
            disp_vsync_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            pending_q    <= pending_d;
            disp_vsync_q <= disp_vsync;
        end
    end

    // Writer next state; a swap overrides everything and restarts in IDLE
    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        pending_d = pending_q;
        if (swap) begin
            state_d   = StIdle;
            pending_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cam_vsync) begin
                        state_d   = StCapture;
                        pix_cnt_d = '0;
                    end
                end
                StCapture: begin
                    // Final pixel wins over a coincident cam_vsync
                    if (last_pix) begin
                        state_d   = StDone;
                        pending_d = 1'b1;
                    end else if (cam_vsync) begin
                        pix_cnt_d = '0;
                    end else if (cam_valid) begin
                        pix_cnt_d = pix_cnt_q + AddrOne;
                    end
                end
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    // Write strobe decode: only pixels seen in CAPTURE reach the RAM
    always_comb begin
        wr_en_d = (state_q == StCapture) & cam_valid & ~swap;
    end

    // Registered write port; address/data hold between writes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en <= wr_en_d;
            if (wr_en_d) begin
                wr_addr_q <= pix_cnt_q;
                wr_data_q <= cam_data;
            end
        end
    end

    // Bank selects change only at a swap edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b1;
        end else if (swap) begin
            rd_bank_q <= wr_bank_q;
            wr_bank_q <= ~wr_bank_q;
        end
    end

    // Read counter: held at 0 during VSync, wraps at the end of the frame
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_cnt_q <= '0;
        end else if (!disp_vsync) begin
            rd_cnt_q <= '0;
        end else if (rd_req) begin
            rd_cnt_q <= (rd_cnt_q == LastPix) ? '0 : rd_cnt_q + AddrOne;
        end
    end

`ifdef FB_FRAME_STATS_EN
    logic [15:0] drop_cnt_q, short_cnt_q;
    logic        drop_evt, abort_evt;

    // A swap only happens in DONE, so a swap-cycle cam_vsync is a DONE drop
    assign drop_evt  = cam_vsync & ((state_q == StDone) | last_pix);
    assign abort_evt = cam_vsync & (state_q == StCapture) & ~last_pix & ~swap;

    // Saturating frame statistics
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt_q  <= '0;
            short_cnt_q <= '0;
        end else begin
            if (drop_evt && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (abort_evt && short_cnt_q != 16'hFFFF) begin
                short_cnt_q <= short_cnt_q + 16'd1;
            end
        end
    end

    assign drop_cnt  = drop_cnt_q;
    assign short_cnt = short_cnt_q;
`else
    assign drop_cnt  = 16'h0000;
    assign short_cnt = 16'h0000;
`endif

    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_bank    = wr_bank_q;
    assign rd_bank    = rd_bank_q;
    assign frame_sync = rd_bank_q;
    assign rd_addr    = rd_cnt_q;

endmodule

// File: tb/tb_fb_bank_ctrl.sv
// Directed testbench for fb_bank_ctrl using a reduced frame size.
module tb_fb_bank_ctrl;

    localparam int unsigned AW = 19;
    localparam int unsigned FP = 48;
`ifdef FB_FRAME_STATS_EN
    localparam int StatsOn = 1;
`else
    localparam int StatsOn = 0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          cam_vsync, cam_valid;
    logic [23:0]   cam_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          wr_bank;
    logic          disp_vsync, rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_bank, frame_sync;
    logic [15:0]   drop_cnt, short_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    fb_bank_ctrl #(.ADDR_W(AW), .FRAME_PIXELS(FP)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cam_vsync  (cam_vsync),
        .cam_valid  (cam_valid),
        .cam_data   (cam_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_bank    (wr_bank),
        .disp_vsync (disp_vsync),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_bank    (rd_bank),
        .frame_sync (frame_sync),
        .drop_cnt   (drop_cnt),
        .short_cnt  (short_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pix(input int f, input int i);
        return 24'((f << 16) ^ (i * 37) ^ 24'h5A0000);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; cam_vsync = 1'b0; cam_valid = 1'b0; cam_data = '0;
        disp_vsync = 1'b1; rd_req = 1'b0;
        step(); step();
        rstn = 1'b1;
        step();
    endtask

    // cam_vsync then FP pixels; optionally checks every write
    task automatic capture_frame(input int f, input bit check, input logic exp_bank);
        cam_vsync = 1'b1; step(); cam_vsync = 1'b0;
        for (int i = 0; i < int'(FP); i++) begin
            cam_valid = 1'b1; cam_data = pix(f, i);
            step();
            if (check) begin
                n_tests++;
                if (wr_en !== 1'b1 || wr_addr !== AW'(i) || wr_data !== pix(f, i) ||
                    wr_bank !== exp_bank) begin
                    n_fail++;
                    $display("FAIL wr_pixel %0d: got en=%b addr=%0d data=%h bank=%b, want en=1 addr=%0d data=%h bank=%b",
                             i, wr_en, wr_addr, wr_data, wr_bank, i, pix(f, i), exp_bank);
                end
            end
        end
        cam_valid = 1'b0;
        step();
        if (check) begin
            n_tests++;
            if (wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_en_after_frame: got %b want 0", wr_en);
            end
        end
    endtask

    task automatic test_reset();
        logic [AW+AW+24+3+32:0] got, exp;
        do_reset();
        got = {wr_en, wr_addr, wr_data, wr_bank, rd_bank, frame_sync, rd_addr, drop_cnt, short_cnt};
        exp = {1'b0, AW'(0), 24'h0, 1'b0, 1'b1, 1'b1, AW'(0), 16'h0, 16'h0};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_values: got %h want %h", got, exp);
        end
        // IDLE ignores cam_valid; a display fall without pending does not swap
        cam_valid = 1'b1; cam_data = 24'h123456; disp_vsync = 1'b0;
        step();
        n_tests++;
        if (wr_en !== 1'b0 || rd_bank !== 1'b1 || wr_bank !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_write: got en=%b rd_bank=%b wr_bank=%b want 0 1 0",
                     wr_en, rd_bank, wr_bank);
        end
        cam_valid = 1'b0; disp_vsync = 1'b1;
        step();
    endtask

    task automatic test_full_frame();
        do_reset();
        capture_frame(1, 1'b1, 1'b0);
        n_tests++;
        if (rd_bank !== 1'b1 || wr_bank !== 1'b0) begin
            n_fail++;
            $display("FAIL no_swap_before_fall: got rd=%b wr=%b want 1 0", rd_bank, wr_bank);
        end
        disp_vsync = 1'b0; step();
        n_tests++;
        if (rd_bank !== 1'b0 || wr_bank !== 1'b1 || frame_sync !== 1'b0) begin
            n_fail++;
            $display("FAIL swap: got rd=%b wr=%b fs=%b want 0 1 0", rd_bank, wr_bank, frame_sync);
        end
        disp_vsync = 1'b1; step();
        disp_vsync = 1'b0; step();
        n_tests++;
        if (rd_bank !== 1'b0 || wr_bank !== 1'b1) begin
            n_fail++;
            $display("FAIL repeat_bank: got rd=%b wr=%b want 0 1", rd_bank, wr_bank);
        end
        disp_vsync = 1'b1; step();
    endtask

    task automatic test_reader();
        disp_vsync = 1'b0; rd_req = 1'b0; step();
        disp_vsync = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < int'(FP); i++) begin
            n_tests++;
            if (rd_addr !== AW'(i)) begin
                n_fail++;
                $display("FAIL rd_addr_seq %0d: got %0d want %0d", i, rd_addr, i);
            end
            step();
        end
        n_tests++;
        if (rd_addr !== AW'(0)) begin
            n_fail++;
            $display("FAIL rd_wrap: got %0d want 0", rd_addr);
        end
        repeat (5) step();
        n_tests++;
        if (rd_addr !== AW'(5)) begin
            n_fail++;
            $display("FAIL rd_after_wrap: got %0d want 5", rd_addr);
        end
        disp_vsync = 1'b0; step(); step();
        n_tests++;
        if (rd_addr !== AW'(0)) begin
            n_fail++;
            $display("FAIL rd_vsync_clear: got %0d want 0", rd_addr);
        end
        disp_vsync = 1'b1; step();
        n_tests++;
        if (rd_addr !== AW'(1)) begin
            n_fail++;
            $display("FAIL rd_first_after_vsync: got %0d want 1", rd_addr);
        end
        rd_req = 1'b0; step();
        n_tests++;
        if (rd_addr !== AW'(1)) begin
            n_fail++;
            $display("FAIL rd_hold: got %0d want 1", rd_addr);
        end
    endtask

    task automatic test_short_frame();
        do_reset();
        cam_vsync = 1'b1; step(); cam_vsync = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cam_valid = 1'b1; cam_data = pix(2, i); step();
        end
        cam_valid = 1'b0;
        // capture_frame's cam_vsync aborts the short frame
        capture_frame(3, 1'b1, 1'b0);
        n_tests++;
        if (short_cnt !== 16'(StatsOn) || drop_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL short_cnt: got short=%0d drop=%0d want %0d 0", short_cnt, drop_cnt, StatsOn);
        end
        disp_vsync = 1'b0; step(); disp_vsync = 1'b1; step();
        n_tests++;
        if (rd_bank !== 1'b0 || wr_bank !== 1'b1) begin
            n_fail++;
            $display("FAIL short_swap: got rd=%b wr=%b want 0 1", rd_bank, wr_bank);
        end
    endtask

    task automatic test_drop();
        int writes;
        do_reset();
        capture_frame(4, 1'b0, 1'b0);
        cam_vsync = 1'b1; step(); cam_vsync = 1'b0;
        writes = 0;
        cam_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (wr_en === 1'b1) writes++;
        end
        n_tests++;
        if (writes !== 0) begin
            n_fail++;
            $display("FAIL done_no_write: got %0d writes want 0", writes);
        end
        // Swap and cam_vsync in the same cycle: counted as a drop, no capture
        disp_vsync = 1'b0; cam_vsync = 1'b1; step();
        disp_vsync = 1'b1; cam_vsync = 1'b0;
        step(); step();
        n_tests++;
        if (wr_en !== 1'b0 || rd_bank !== 1'b0 || wr_bank !== 1'b1) begin
            n_fail++;
            $display("FAIL swap_vsync_ignored: got en=%b rd=%b wr=%b want 0 0 1", wr_en, rd_bank, wr_bank);
        end
        cam_valid = 1'b0;
        n_tests++;
        if (drop_cnt !== 16'(2 * StatsOn) || short_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL drop_cnt: got drop=%0d short=%0d want %0d 0", drop_cnt, short_cnt, 2 * StatsOn);
        end
        capture_frame(5, 1'b1, 1'b1);
        disp_vsync = 1'b0; step(); disp_vsync = 1'b1; step();
        n_tests++;
        if (rd_bank !== 1'b1 || wr_bank !== 1'b0 || frame_sync !== 1'b1) begin
            n_fail++;
            $display("FAIL second_swap: got rd=%b wr=%b fs=%b want 1 0 1", rd_bank, wr_bank, frame_sync);
        end
    endtask

    task automatic test_coincident();
        do_reset();
        cam_vsync = 1'b1; step(); cam_vsync = 1'b0;
        for (int i = 0; i < int'(FP) - 1; i++) begin
            cam_valid = 1'b1; cam_data = pix(6, i); step();
        end
        // Final pixel, cam_vsync and display fall all on one edge
        cam_data = pix(6, int'(FP) - 1); cam_vsync = 1'b1; disp_vsync = 1'b0;
        step();
        cam_valid = 1'b0; cam_vsync = 1'b0;
        n_tests++;
        if (wr_en !== 1'b1 || wr_addr !== AW'(FP - 1) || rd_bank !== 1'b1 || wr_bank !== 1'b0) begin
            n_fail++;
            $display("FAIL coincident_no_swap: got en=%b addr=%0d rd=%b wr=%b want 1 %0d 1 0",
                     wr_en, wr_addr, rd_bank, wr_bank, FP - 1);
        end
        step();
        n_tests++;
        if (rd_bank !== 1'b1) begin
            n_fail++;
            $display("FAIL coincident_low_hold: got rd=%b want 1", rd_bank);
        end
        disp_vsync = 1'b1; step();
        disp_vsync = 1'b0; step();
        n_tests++;
        if (rd_bank !== 1'b0 || wr_bank !== 1'b1 || frame_sync !== 1'b0) begin
            n_fail++;
            $display("FAIL coincident_next_swap: got rd=%b wr=%b fs=%b want 0 1 0", rd_bank, wr_bank, frame_sync);
        end
        n_tests++;
        if (drop_cnt !== 16'(StatsOn) || short_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL coincident_stats: got drop=%0d short=%0d want %0d 0", drop_cnt, short_cnt, StatsOn);
        end
        disp_vsync = 1'b1; step();
    endtask

    task automatic test_reset_mid();
        logic [AW+AW+24+3+32:0] got, exp;
        do_reset();
        capture_frame(7, 1'b0, 1'b0);
        disp_vsync = 1'b0; step(); disp_vsync = 1'b1;
        rd_req = 1'b1;
        cam_vsync = 1'b1; step(); cam_vsync = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cam_valid = 1'b1; cam_data = pix(8, i); step();
        end
        rstn = 1'b0;
        #1;
        got = {wr_en, wr_addr, wr_data, wr_bank, rd_bank, frame_sync, rd_addr, drop_cnt, short_cnt};
        exp = {1'b0, AW'(0), 24'h0, 1'b0, 1'b1, 1'b1, AW'(0), 16'h0, 16'h0};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_values: got %h want %h", got, exp);
        end
        step();
        rstn = 1'b1; cam_valid = 1'b0; rd_req = 1'b0;
        step();
        cam_vsync = 1'b1; step(); cam_vsync = 1'b0;
        cam_valid = 1'b1; cam_data = pix(9, 0); step();
        cam_valid = 1'b0;
        n_tests++;
        if (wr_en !== 1'b1 || wr_addr !== AW'(0) || wr_data !== pix(9, 0) ||
            wr_bank !== 1'b0 || rd_bank !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_write: got en=%b addr=%0d data=%h bank=%b rd=%b want 1 0 %h 0 1",
                     wr_en, wr_addr, wr_data, wr_bank, rd_bank, pix(9, 0));
        end
        step();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_reader();
        test_short_frame();
        test_drop();
        test_coincident();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_bank_ctrl.md
# fb_bank_ctrl

Double-buffer bank controller between the camera capture stream and the HDMI debug timing generator. It owns the bank select and the write and read addressing for two frame-buffer RAM banks. The camera writes one bank while the display reads the other. Banks swap only at a display vertical sync, and only after a complete camera frame has been captured. The block sits between the camera pixel interface, the two frame-buffer RAMs, and the HDMI timing generator, whose `Mem_Read` and `FraimSync` it serves.

## Interface
Parameters:
- `ADDR_W`, 19: pixel address width.
- `FRAME_PIXELS`, 307200: pixels per frame (640x480).

Ports:
- `clk`  in  1: pixel clock.
- `rstn`  in  1: reset, asynchronous, active-low.
- `cam_vsync`  in  1: one-cycle frame-start pulse, synchronous to `clk`.
- `cam_valid`  in  1: camera pixel valid.
- `cam_data`  in  24: camera pixel, RGB888.
- `wr_en`  out  1: RAM write strobe.
- `wr_addr`  out  ADDR_W: RAM write address.
- `wr_data`  out  24: RAM write data.
- `wr_bank`  out  1: bank being written.
- `disp_vsync`  in  1: display VSync, active-low level, from the timing generator.
- `rd_req`  in  1: display read request (`Mem_Read`).
- `rd_addr`  out  ADDR_W: RAM read address.
- `rd_bank`  out  1: bank being displayed; drives read-data mux select.
- `frame_sync`  out  1: equals `rd_bank`; feeds `FraimSync`.
- `drop_cnt`  out  16: frames dropped (see Configuration).
- `short_cnt`  out  16: short frames aborted (see Configuration).

## Operation
Writer FSM has three states: IDLE, CAPTURE, DONE.
- IDLE: on `cam_vsync`, go to CAPTURE and clear the pixel count to 0. `cam_valid` is ignored.
- CAPTURE: each `cam_valid` cycle writes `cam_data` at address = pixel count, then increments the count.
  - When the accepted pixel is count == FRAME_PIXELS-1: go to DONE and set `pending`=1.
  - A `cam_vsync` while count < FRAME_PIXELS, with no same-cycle final pixel, aborts the frame: count clears to 0, the state stays CAPTURE in the same bank, and `short_cnt` increments.
  - If `cam_vsync` and the final pixel coincide, the final pixel wins: the state goes to DONE and the pulse is treated as a DONE-state `cam_vsync`.
- DONE: `cam_valid` is ignored. Each `cam_vsync` increments `drop_cnt`.

Swap:
- A swap occurs on a falling edge of `disp_vsync` (previous value registered 1, current value 0) when the registered `pending` is 1.
- On a swap, all updates happen on the same edge:
  - `rd_bank` <= `wr_bank`
  - `wr_bank` <= ~`wr_bank`
  - `pending` <= 0
  - writer FSM <= IDLE
- A `cam_vsync` in the swap cycle is counted as dropped and does not start a capture.
- A falling edge with `pending`=0 does nothing; the display repeats the current bank.

Reader:
- The read counter is forced to 0 while `disp_vsync`=0.
- Otherwise it increments after each cycle with `rd_req`=1.
- It wraps from FRAME_PIXELS-1 to 0.
- `rd_addr` is the counter value directly, with no register stage.

The counter and FSM run at the pixel clock. Every write is single-cycle; there is no backpressure.

## Timing
Reset values:
- `wr_en`=0, `wr_addr`=0, `wr_data`=0.
- `wr_bank`=0, `rd_bank`=1, `frame_sync`=1.
- `rd_addr`=0, `drop_cnt`=0, `short_cnt`=0.
- `pending`=0, FSM=IDLE.

Write path:
- All write outputs are registered, with 1-cycle latency: `cam_valid` at cycle N in CAPTURE gives `wr_en`=1 at N+1, with the matching `wr_addr`/`wr_data`.
- `wr_en` is 0 in every other cycle.

Read path:
- `rd_addr` for the first `rd_req` cycle after VSync returns high is 0.
- RAM read latency is external to this block.

Swap timing:
- `pending` is set at the edge that accepts the final pixel.
- A `disp_vsync` falling edge in that same cycle sees the old `pending`=0, so the swap waits for the next display frame.
- `rd_bank`, `wr_bank` and `frame_sync` change only at a swap edge.

Counter widths:
- The pixel count is ADDR_W bits and never exceeds FRAME_PIXELS-1.
- `drop_cnt` and `short_cnt` saturate at 16'hFFFF.

Reset asserted mid-frame: all state returns to the reset values immediately. The partial frame is discarded and never displayed.

## Configuration
- Macro `FB_FRAME_STATS_EN`.
- Defined: `drop_cnt` and `short_cnt` are implemented as specified.
- Undefined: both outputs are tied to 16'h0000 and their counters are not built. All other behaviour is identical.

## Test plan
- Reset, then `cam_vsync` plus FRAME_PIXELS consecutive `cam_valid` -> `wr_en` count 307200 with `wr_addr` 0..307199 and `wr_bank`=0; `pending`=1; at the next `disp_vsync` fall, `rd_bank`=0, `wr_bank`=1, `frame_sync`=0.
- `rd_req` high for 640 cycles on each of 480 lines, with `disp_vsync` high -> `rd_addr` runs 0..307199 contiguously; after a VSync low period the next read address is 0.
- Short frame: 1000 pixels, then `cam_vsync`, then a full frame -> `short_cnt`=1; the full frame lands at `wr_addr` 0.. in bank 0; one swap follows.
- Two camera frames complete before any display VSync: the second `cam_vsync` arrives in DONE -> `drop_cnt`=1 and no writes occur until the swap.
- Final pixel and `disp_vsync` fall in the same cycle -> no swap on that edge; the swap happens on the next falling edge.
- `rstn` pulsed low mid-capture at pixel 5000 -> all outputs return to reset values; a restarted frame writes from address 0 in bank 0.
